belief_update: RTL and testbench
================================

BELIEF_UPDATE -- requirements
Module: belief_update

Interface
REQ-001 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- en_belief  in  1  start pulse from the observation generator
- observation  in  1  observed symbol o
- action  in  2  action a, valid values 0..2
- trans  in  16 x [3][2][2]  trans[a][s][s'] = P(s'|s,a), Q0.16
- observe  in  16 x [3][2][2]  observe[a][s][o] = P(o|s,a), Q0.16
- load_init  in  1  load initial belief
- init_belief  in  16  value for load_init
- belief_out  out  16  b0 = P(state=0), Q0.16
- belief_valid  out  1  one-cycle pulse when an update completes
- busy  out  1  update in progress
- degenerate  out  1  one-cycle pulse: normaliser was zero
- update_count  out  16  completed-update counter (see Configuration)

Function
REQ-002 SHALL define b1 = 16'hFFFF - b0.
REQ-003 SHALL implement FSM states IDLE, PRED, CORR, DIV, DONE.
REQ-004 In IDLE with en_belief=1 at edge k, SHALL capture action, observation and b0, then enter PRED.
REQ-005 PRED (edge k+1) SHALL register pred[s'] = (trans[a][0][s']*b0 + trans[a][1][s']*b1) >> 16, saturated to 16'hFFFF; enter CORR.
REQ-006 CORR (edge k+2) SHALL register num[s'] = (observe[a][s'][o]*pred[s']) >> 16 and den = num0 + num1 (17 bits).
REQ-007 In CORR, SHALL enter DIV if den != 0; otherwise SHALL enter DONE with the degenerate flag set.
REQ-008 DIV SHALL be a restoring divider for q = floor(num0*65536/den), one quotient bit per cycle, 17 cycles, then enter DONE (edge k+19).
REQ-009 At edge k+20 (DONE to IDLE), SHALL load belief_out = min(q, 16'hFFFF) and set belief_valid=1 for exactly one cycle.
REQ-010 For a degenerate update, SHALL leave belief_out unchanged; the DONE-to-IDLE transition occurs at edge k+3, belief_valid and degenerate each pulse for one cycle.
REQ-011 busy SHALL be 1 in every state except IDLE.
REQ-012 SHALL ignore en_belief while not in IDLE; ignored requests are not queued.
REQ-013 On load_init=1 in IDLE, SHALL set belief_out=init_belief at the next edge without a belief_valid pulse.
REQ-014 SHALL ignore load_init while busy.
REQ-015 If load_init and en_belief are both 1 in IDLE, en_belief SHALL win and load_init is dropped.
REQ-016 SHALL assume trans and observe are stable while busy; action and observation are used only as captured.
REQ-017 SHALL treat action=3 as action 0.

Reset
REQ-018 On rst_n low, SHALL asynchronously force state=IDLE, belief_out=16'h8000, belief_valid=0, busy=0, degenerate=0, update_count=0 and all datapath registers to 0.
REQ-019 Reset mid-update SHALL abort the update with no belief_valid pulse.

Configuration
REQ-020 Macro BELIEF_STATS_EN defined: update_count SHALL increment by 1 on each non-degenerate belief_valid pulse and saturate at 16'hFFFF.
REQ-021 Macro BELIEF_STATS_EN undefined: update_count SHALL be tied to 0, with no counter logic.

Verification
REQ-022 Bench SHALL cover the following scenarios:
- Nominal update: b0=8000, a=0, trans[0] identity (FFFF diagonal, 0 elsewhere), observe[0][0][0]=C000, observe[0][1][0]=4000, o=0, en at edge k -> belief_out=C001 and belief_valid pulse at edge k+20; busy high edges k..k+19.
- Degenerate: observe[a][0][o]=observe[a][1][o]=0 -> belief_out unchanged and degenerate plus belief_valid pulse at edge k+3; update_count unchanged.
- Saturation: b0=FFFF, identity trans, observe[a][*][o]=8000 -> q=65536 clamped, belief_out=FFFF.
- Busy ignore: second en_belief at edge k+5 -> exactly one belief_valid pulse; load_init=1 with init_belief=1234 while busy -> no effect; the same load in IDLE -> belief_out=1234 next edge, no valid pulse.
- Reset mid-DIV: rst_n low at edge k+10 -> belief_out=8000, busy=0, no valid pulse; a new en after release completes normally at +20.
- With BELIEF_STATS_EN: three nominal updates plus one degenerate -> update_count=3; without the macro, update_count=0 throughout.

Source files
------------

// File: rtl/belief_update.sv
// Two-state Bayesian belief filter: predict, correct, then normalise with a serial restoring divider.
// Optional BELIEF_STATS_EN adds a saturating counter of completed non-degenerate updates.
module belief_update (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_belief,
  input  logic                         observation,
  input  logic [1:0]                   action,
  input  logic [2:0][1:0][1:0][15:0]   trans,
  input  logic [2:0][1:0][1:0][15:0]   observe,
  input  logic                         load_init,
  input  logic [15:0]                  init_belief,
  output logic [15:0]                  belief_out,
  output logic                         belief_valid,
  output logic                         busy,
  output logic                         degenerate,
  output logic [15:0]                  update_count
);

  typedef enum logic [2:0] {IDLE, PRED, CORR, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [1:0]  act_q;
  logic        obs_q;
  logic [15:0] b0_q;
  logic [15:0] pred0, pred1;
  logic [15:0] num0;
  logic [16:0] den;
  logic [16:0] rem;
  logic [16:0] quo;
  logic [4:0]  cnt;
  logic        deg_q;

  logic [15:0] b1;
  logic [32:0] psum0, psum1;
  logic [15:0] pred0_c, pred1_c;
  logic [31:0] nprod0, nprod1;
  logic [15:0] num0_c, num1_c;
  logic [16:0] den_c;
  logic [16:0] rem_cur;
  logic [17:0] trial, diff;
  logic        ge;

  assign b1 = 16'hFFFF - b0_q;

  always_comb begin
    psum0   = 33'(trans[act_q][0][0]) * 33'(b0_q) + 33'(trans[act_q][1][0]) * 33'(b1);
    psum1   = 33'(trans[act_q][0][1]) * 33'(b0_q) + 33'(trans[act_q][1][1]) * 33'(b1);
    pred0_c = psum0[32] ? 16'hFFFF : psum0[31:16];
    pred1_c = psum1[32] ? 16'hFFFF : psum1[31:16];
    nprod0  = 32'(observe[act_q][0][obs_q]) * 32'(pred0);
    nprod1  = 32'(observe[act_q][1][obs_q]) * 32'(pred1);
    num0_c  = nprod0[31:16];
    num1_c  = nprod1[31:16];
    den_c   = 17'(num0_c) + 17'(num1_c);
  end

  // Since num0 <= den, the top 15 quotient bits of num0*2^16/den are zero; the divide
  // starts with num0[15:1] as remainder and shifts in num0[0] followed by zeros.
  always_comb begin
    rem_cur = (cnt == 5'd0) ? {2'b00, num0[15:1]} : rem;
    trial   = {rem_cur, (cnt == 5'd0) ? num0[0] : 1'b0};
    diff    = trial - {1'b0, den};
    ge      = (trial >= {1'b0, den});
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    case (state)
      IDLE: if (en_belief) state_nx = PRED;
      PRED: state_nx = CORR;
      CORR: state_nx = (den_c != 17'd0) ? DIV : DONE;
      DIV:  if (cnt == 5'd16) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      act_q        <= '0;
      obs_q        <= 1'b0;
      b0_q         <= '0;
      pred0        <= '0;
      pred1        <= '0;
      num0         <= '0;
      den          <= '0;
      rem          <= '0;
      quo          <= '0;
      cnt          <= '0;
      deg_q        <= 1'b0;
      belief_out   <= 16'h8000;
      belief_valid <= 1'b0;
      degenerate   <= 1'b0;
    end else begin
      state        <= state_nx;
      belief_valid <= 1'b0;
      degenerate   <= 1'b0;
      case (state)
        IDLE: begin
          if (en_belief) begin
            act_q <= (action == 2'd3) ? 2'd0 : action;
            obs_q <= observation;
            b0_q  <= belief_out;
          end else if (load_init) begin
            belief_out <= init_belief;
          end
        end
        PRED: begin
          pred0 <= pred0_c;
          pred1 <= pred1_c;
        end
        CORR: begin
          num0  <= num0_c;
          den   <= den_c;
          cnt   <= '0;
          quo   <= '0;
          deg_q <= (den_c == 17'd0);
        end
        DIV: begin
          rem <= ge ? diff[16:0] : trial[16:0];
          quo <= {quo[15:0], ge};
          cnt <= cnt + 5'd1;
        end
        DONE: begin
          belief_valid <= 1'b1;
          degenerate   <= deg_q;
          if (!deg_q) belief_out <= quo[16] ? 16'hFFFF : quo[15:0];
        end
        default: ;
      endcase
    end
  end

`ifdef BELIEF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      update_count <= '0;
    else if (state == DONE && !deg_q && update_count != 16'hFFFF)
      update_count <= update_count + 16'd1;
  end
`else
  assign update_count = '0;
`endif

endmodule

// File: tb/tb_belief_update.sv
// Randomized self-checking bench for belief_update against a plain-arithmetic Bayes model.
module tb_belief_update;

  logic                       clk;
  logic                       rst_n;
  logic                       en_belief;
  logic                       observation;
  logic [1:0]                 action;
  logic [2:0][1:0][1:0][15:0] trans;
  logic [2:0][1:0][1:0][15:0] observe;
  logic                       load_init;
  logic [15:0]                init_belief;
  logic [15:0]                belief_out;
  logic                       belief_valid;
  logic                       busy;
  logic                       degenerate;
  logic [15:0]                update_count;

  int n_checks = 0;
  int n_errors = 0;
  int vcnt = 0;
  logic [15:0] m_belief;
  int m_count;

  belief_update dut (
    .clk(clk), .rst_n(rst_n), .en_belief(en_belief), .observation(observation),
    .action(action), .trans(trans), .observe(observe), .load_init(load_init),
    .init_belief(init_belief), .belief_out(belief_out), .belief_valid(belief_valid),
    .busy(busy), .degenerate(degenerate), .update_count(update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (belief_valid) vcnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_count();
`ifdef BELIEF_STATS_EN
    return m_count;
`else
    return 0;
`endif
  endfunction

  // Bayes step: predict with the transition matrix, weight by the observation
  // likelihood, normalise; all in wide integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] b, input logic [1:0] a,
                                        input logic o, output bit deg);
    int ai;
    longint p [2];
    longint n [2];
    longint den, q;
    ai = (a == 2'd3) ? 0 : int'(a);
    for (int s = 0; s < 2; s++) begin
      p[s] = (longint'(trans[ai][0][s]) * longint'(b) +
              longint'(trans[ai][1][s]) * (65535 - longint'(b))) / 65536;
      if (p[s] > 65535) p[s] = 65535;
      n[s] = longint'(observe[ai][s][o]) * p[s] / 65536;
    end
    den = n[0] + n[1];
    deg = (den == 0);
    if (deg) return b;
    q = n[0] * 65536 / den;
    if (q > 65535) q = 65535;
    return q[15:0];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; en_belief = 1'b0; load_init = 1'b0;
    repeat (3) tick();
    check("reset_belief", belief_out, 16'h8000);
    check("reset_busy", busy, 0);
    check("reset_valid", belief_valid, 0);
    check("reset_degen", degenerate, 0);
    check("reset_count", update_count, 0);
    rst_n = 1'b1;
    m_belief = 16'h8000;
    m_count = 0;
  endtask

  task automatic do_load(input logic [15:0] v);
    int v0;
    v0 = vcnt;
    load_init = 1'b1; init_belief = v;
    tick();
    load_init = 1'b0;
    check("load_value", belief_out, v);
    tick();
    check("load_no_valid", vcnt - v0, 0);
    m_belief = v;
  endtask

  task automatic run_update(input logic [1:0] a, input logic o, input logic with_load);
    logic [15:0] exp_b;
    bit deg;
    int lat, v0;
    bit busy_ok;
    exp_b = model(m_belief, a, o, deg);
    v0 = vcnt;
    action = a; observation = o; en_belief = 1'b1;
    load_init = with_load; init_belief = 16'($urandom);
    tick();
    en_belief = 1'b0; load_init = 1'b0;
    action = 2'($urandom); observation = 1'($urandom);
    lat = 0; busy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      if (belief_valid) begin
        lat = i;
        break;
      end
    end
    check("busy_during", busy_ok, 1);
    check("latency", lat, deg ? 3 : 20);
    check("belief", belief_out, exp_b);
    check("degenerate", degenerate, deg);
    check("busy_after", busy, 0);
    tick();
    check("valid_one_cycle", belief_valid, 0);
    check("valid_count", vcnt - v0, 1);
    if (!deg && m_count < 65535) m_count++;
    m_belief = exp_b;
    check("update_count", update_count, exp_count());
  endtask

  task automatic set_identity(input int a);
    trans[a][0][0] = 16'hFFFF; trans[a][0][1] = 16'h0000;
    trans[a][1][0] = 16'h0000; trans[a][1][1] = 16'hFFFF;
  endtask

  task automatic set_nominal();
    set_identity(0);
    observe[0][0][0] = 16'hC000;
    observe[0][1][0] = 16'h4000;
  endtask

  initial begin
    int v0;
    logic [1:0] a;
    logic o;
    int ai;
    logic [15:0] exp_b;
    bit deg;

    en_belief = 1'b0; load_init = 1'b0; observation = 1'b0; action = '0;
    init_belief = '0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int s = 0; s < 2; s++)
        for (int t = 0; t < 2; t++) begin
          trans[i][s][t]   = 16'($urandom);
          observe[i][s][t] = 16'($urandom) | 16'h0100;
        end
    do_reset();

    // Nominal update
    set_nominal();
    run_update(2'd0, 1'b0, 1'b0);
    check("nominal_c001", belief_out, 16'hC001);

    // Degenerate: both likelihoods zero
    observe[0][0][1] = '0; observe[0][1][1] = '0;
    run_update(2'd0, 1'b1, 1'b0);
    check("degen_unchanged", belief_out, 16'hC001);

    // Saturation of q = 65536
    do_load(16'hFFFF);
    set_identity(0);
    observe[0][0][0] = 16'h8000; observe[0][1][0] = 16'h8000;
    run_update(2'd0, 1'b0, 1'b0);
    check("saturate", belief_out, 16'hFFFF);

    // Busy: repeated en and load_init are ignored
    set_nominal();
    do_load(16'h8000);
    exp_b = model(m_belief, 2'd0, 1'b0, deg);
    v0 = vcnt;
    action = 2'd0; observation = 1'b0; en_belief = 1'b1;
    tick();
    en_belief = 1'b0;
    repeat (4) tick();
    en_belief = 1'b1;
    tick();
    en_belief = 1'b0;
    load_init = 1'b1; init_belief = 16'h1234;
    tick();
    load_init = 1'b0;
    repeat (40) tick();
    check("busy_one_valid", vcnt - v0, 1);
    check("busy_ignore_belief", belief_out, exp_b);
    check("busy_ignore_c001", belief_out, 16'hC001);
    if (m_count < 65535) m_count++;
    m_belief = exp_b;
    do_load(16'h1234);

    // Reset in the middle of the divide
    v0 = vcnt;
    action = 2'd0; observation = 1'b0; en_belief = 1'b1;
    tick();
    en_belief = 1'b0;
    repeat (9) tick();
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_belief", belief_out, 16'h8000);
    check("midreset_busy", busy, 0);
    check("midreset_count", update_count, 0);
    tick();
    rst_n = 1'b1;
    m_belief = 16'h8000; m_count = 0;
    repeat (25) tick();
    check("midreset_no_valid", vcnt - v0, 0);
    run_update(2'd0, 1'b0, 1'b0);
    check("after_reset_c001", belief_out, 16'hC001);

    // Counter: three nominal updates plus one degenerate
    do_reset();
    set_nominal();
    observe[2][0][1] = '0; observe[2][1][1] = '0;
    run_update(2'd0, 1'b0, 1'b1);
    run_update(2'd0, 1'b0, 1'b0);
    run_update(2'd0, 1'b0, 1'b0);
    run_update(2'd2, 1'b1, 1'b0);
`ifdef BELIEF_STATS_EN
    check("stats_total", update_count, 3);
`else
    check("stats_total", update_count, 0);
`endif

    // Randomized updates
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 3; i++)
        for (int s = 0; s < 2; s++)
          for (int t = 0; t < 2; t++) begin
            trans[i][s][t]   = 16'($urandom);
            observe[i][s][t] = 16'($urandom);
          end
      a = 2'($urandom_range(0, 3));
      o = 1'($urandom);
      ai = (a == 2'd3) ? 0 : int'(a);
      if ($urandom_range(0, 5) == 0) begin
        observe[ai][0][o] = '0;
        observe[ai][1][o] = '0;
      end
      if ($urandom_range(0, 3) == 0) do_load(16'($urandom));
      run_update(a, o, 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
